uart_tx_arb: RTL and testbench
==============================

Name: uart_tx_arb

Overview:
Round-robin arbiter that shares one UART transmitter byte stream between NUM_REQ requesters. Each requester presents bytes on a valid/ready interface with a last flag marking the end of a burst. The arbiter grants one requester at a time and holds the grant for the whole burst, so bursts never interleave on the serial line. It sits between on-chip byte sources (command responders, debug, FIFO drains) and the uart_tx datapath in the single tx clock domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 8, byte width; matches the UART data width
MAX_BURST, 16, max bytes per grant before forced release (>=1)

Ports:
clk_i  in  1  single clock (tx domain)
rst_n_i  in  1  synchronous reset, active low
req_v_i  in  NUM_REQ  per-requester byte valid
req_d_i  in  NUM_REQ*DATA_WIDTH  per-requester byte; requester k on bits [k*DATA_WIDTH +: DATA_WIDTH]
req_last_i  in  NUM_REQ  last byte of burst, qualified by req_v_i
req_rdy_o  out  NUM_REQ  per-requester ready; byte k accepted when req_v_i[k] && req_rdy_o[k]
tx_d_o  out  DATA_WIDTH  byte to uart_tx
tx_v_o  out  1  byte valid to uart_tx
tx_rdy_i  in  1  uart_tx can accept a byte this cycle
gnt_o  out  NUM_REQ  one-hot current grant (0 when idle)
busy_o  out  1  high while a grant is held

Behaviour:
- Reset is synchronous and active-low: on any clk_i edge with rst_n_i=0:
  - state <= ST_IDLE; gnt_o <= 0; busy_o <= 0.
  - Byte counter <= 0.
  - Round-robin pointer <= NUM_REQ-1, so requester 0 has first priority after reset.
- Reset mid-burst aborts the burst immediately. The aborted requester gets no special priority afterwards.
- States:
  - ST_IDLE (busy_o=0, gnt_o=0, tx_v_o=0, req_rdy_o=0).
  - ST_BUSY (busy_o=1, gnt_o one-hot).
- ST_IDLE -> ST_BUSY:
  - When any req_v_i bit is set, grant the first set bit searching upward, wrapping, from pointer+1.
  - Register gnt_o, set pointer <= granted index, counter <= 0.
  - Arbitration latency: exactly 1 cycle from req_v_i rising to gnt_o/busy_o high.
  - No byte is transferred in the arbitration cycle.
- ST_BUSY datapath, combinational, no added latency:
  - tx_d_o = req_d_i slice of the granted index.
  - tx_v_o = req_v_i[granted].
  - req_rdy_o[granted] = tx_rdy_i; all other req_rdy_o bits = 0.
- Transfer event = tx_v_o && tx_rdy_i. On each transfer, counter increments.
- Release (ST_BUSY -> ST_IDLE on the clock after the transfer):
  - On a transfer with req_last_i[granted]=1, or a transfer where counter == MAX_BURST-1.
  - Both conditions in the same cycle count as one release.
- Granted requester deasserting req_v_i mid-burst: grant is held; tx_v_o=0; no timeout, no release.
- tx_rdy_i low: hold tx_d_o/tx_v_o stable as driven by the requester; the counter does not move.
- After a release, at least one ST_IDLE cycle precedes the next grant. Inter-burst gap is therefore >=1 cycle.
- Requesters not granted see req_rdy_o=0; their req_v_i/req_d_i are ignored (no buffering).
- In ST_IDLE, tx_d_o = 0.
- Counter width is clog2(MAX_BURST)+1 and it never wraps.

Test Plan:
- Single burst with no contention:
  - Stimulus: reset, then requester 2 sends 0xA1, 0xA2, 0xA3 (last on 0xA3), tx_rdy_i=1.
  - Required: gnt_o=4'b0100 one cycle after req_v_i; tx_d_o sequence A1, A2, A3 on consecutive cycles; busy_o drops the cycle after A3.
- Simultaneous requests:
  - Stimulus: requesters 0 and 1 each send a 2-byte burst starting in the same cycle after reset.
  - Required: requester 0's bursts complete fully, then one idle cycle, then requester 1; bytes never interleave.
- Round-robin fairness:
  - Stimulus: all 4 requesters continuously request 1-byte bursts (last=1) for 8 grants.
  - Required: grant order 0, 1, 2, 3, 0, 1, 2, 3.
- MAX_BURST cut, with MAX_BURST=16:
  - Stimulus: requester 1 sends 20 bytes with last only on byte 20; requester 3 also requesting.
  - Required: release after byte 16; requester 3 is granted next; requester 1 regains the grant later and sends the remaining 4 bytes.
- Backpressure and requester stall:
  - Stimulus: tx_rdy_i low for 5 cycles mid-burst; the granted requester drops req_v_i for 3 cycles.
  - Required: tx_d_o is held; req_rdy_o follows tx_rdy_i; grant is held throughout; the byte count is exact (no loss or duplication).
- Reset mid-burst:
  - Stimulus: assert rst_n_i=0 for one cycle after byte 2 of a 4-byte burst from requester 3, with requester 0 also requesting.
  - Required: gnt_o=0, busy_o=0 on the next edge; the next grant goes to requester 0.

Source files
------------

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one uart_tx byte stream between NUM_REQ requesters.
// A grant is held for a whole burst (until last, or MAX_BURST bytes) so bursts never interleave.
module uart_tx_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 16
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [NUM_REQ-1:0]            req_v_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_d_i,
    input  logic [NUM_REQ-1:0]            req_last_i,
    output logic [NUM_REQ-1:0]            req_rdy_o,
    output logic [DATA_WIDTH-1:0]         tx_d_o,
    output logic                          tx_v_o,
    input  logic                          tx_rdy_i,
    output logic [NUM_REQ-1:0]            gnt_o,
    output logic                          busy_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t               state_q;
    logic [NUM_REQ-1:0]   gnt_q;
    logic                 busy_q;
    logic [PTR_W-1:0]     ptr_q;
    logic [CNT_W-1:0]     cnt_q;

    logic [PTR_W-1:0]     pick_d;
    logic                 found_d;
    logic [DATA_WIDTH-1:0] sel_d;
    logic                 sel_v;
    logic                 sel_last;
    logic                 xfer;
    logic                 release_now;

    // Search upward from the last granted index, wrapping, so the previous winner goes last.
    always_comb begin
        int idx;
        idx     = 0;
        pick_d  = ptr_q;
        found_d = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr_q) + i) % NUM_REQ;
            if (!found_d && req_v_i[idx]) begin
                found_d = 1'b1;
                pick_d  = PTR_W'(idx);
            end
        end
    end

    // While busy, ptr_q holds the granted index and steers the byte mux.
    always_comb begin
        sel_d    = '0;
        sel_v    = 1'b0;
        sel_last = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (ptr_q == PTR_W'(k)) begin
                sel_d    = req_d_i[k*DATA_WIDTH +: DATA_WIDTH];
                sel_v    = req_v_i[k];
                sel_last = req_last_i[k];
            end
        end
    end

    assign tx_d_o      = busy_q ? sel_d : '0;
    assign tx_v_o      = busy_q & sel_v;
    assign req_rdy_o   = gnt_q & {NUM_REQ{tx_rdy_i}};
    assign xfer        = tx_v_o & tx_rdy_i;
    assign release_now = xfer & (sel_last | (cnt_q == CNT_W'(MAX_BURST - 1)));

    assign gnt_o  = gnt_q;
    assign busy_o = busy_q;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= PTR_W'(NUM_REQ - 1);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (found_d) begin
                        state_q <= ST_BUSY;
                        busy_q  <= 1'b1;
                        gnt_q   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_d;
                        ptr_q   <= pick_d;
                        cnt_q   <= '0;
                    end
                end
                ST_BUSY: begin
                    if (xfer) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    // Returning to idle guarantees a gap cycle before the next grant.
                    if (release_now) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        gnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Directed bench for uart_tx_arb: per-requester byte queues feed the DUT, a monitor logs
// every transfer and grant, and each scenario task compares against hand-written expectations.
module tb_uart_tx_arb;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_v;
    logic [NR*DW-1:0] req_d;
    logic [NR-1:0]    req_last;
    logic [NR-1:0]    req_rdy;
    logic [DW-1:0]    tx_d;
    logic             tx_v;
    logic             tx_rdy;
    logic [NR-1:0]    gnt;
    logic             busy;

    always #5 clk = ~clk;

    uart_tx_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_v_i(req_v), .req_d_i(req_d),
        .req_last_i(req_last), .req_rdy_o(req_rdy), .tx_d_o(tx_d), .tx_v_o(tx_v),
        .tx_rdy_i(tx_rdy), .gnt_o(gnt), .busy_o(busy)
    );

    logic [8:0]    src_q [NR][$];   // {last, byte} per requester
    logic [NR-1:0] stall;
    logic [15:0]   xfer_log[$];     // {granted index, byte}
    int            xfer_cyc[$];
    logic [7:0]    gnt_log[$];
    logic [15:0]   exp_q[$];
    logic [7:0]    exp_g[$];
    logic [NR-1:0] prev_gnt;
    logic [NR-1:0] acc;
    int            cyc;
    int            viol;
    int            errors;
    int            checks;
    logic          to;

    function automatic logic [7:0] onehot_idx(input logic [NR-1:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return 8'(i);
        return 8'hFF;
    endfunction

    function automatic logic pending();
        for (int k = 0; k < NR; k++) if (src_q[k].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push(input int k, input logic [7:0] b, input logic l);
        src_q[k].push_back({l, b});
    endtask

    task automatic drive();
        logic [8:0] h;
        for (int k = 0; k < NR; k++) begin
            if (src_q[k].size() != 0) begin
                h = src_q[k][0];
                req_d[k*DW +: DW] = h[7:0];
                req_last[k]       = h[8];
                req_v[k]          = !stall[k];
            end else begin
                req_d[k*DW +: DW] = '0;
                req_last[k]       = 1'b0;
                req_v[k]          = 1'b0;
            end
        end
    endtask

    // One clock: observe at the negedge, then pop accepted bytes and redrive after the posedge.
    task automatic cycle();
        @(negedge clk);
        acc = req_v & req_rdy;
        if (rst_n && tx_v && tx_rdy) begin
            xfer_log.push_back({onehot_idx(gnt), tx_d});
            xfer_cyc.push_back(cyc);
        end
        if (gnt != prev_gnt && gnt != '0) begin
            gnt_log.push_back(onehot_idx(gnt));
            if (prev_gnt != '0) viol++;
        end
        prev_gnt = gnt;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_n) begin
            for (int k = 0; k < NR; k++) if (acc[k]) void'(src_q[k].pop_front());
        end
        drive();
        #1;
    endtask

    task automatic run_idle(input int bound, output logic timed_out);
        int n;
        n = 0;
        while ((pending() || busy) && n < bound) begin
            cycle();
            n++;
        end
        timed_out = pending() || busy;
    endtask

    task automatic clear_logs();
        xfer_log.delete(); xfer_cyc.delete(); gnt_log.delete();
        exp_q.delete(); exp_g.delete(); viol = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; stall = '0; tx_rdy = 1'b1;
        for (int k = 0; k < NR; k++) src_q[k].delete();
        drive();
        cycle(); cycle();
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = '0; tx_rdy = 1'b1;
        for (int k = 0; k < NR; k++) src_q[k].delete();
        push(1, 8'h33, 1'b1);
        drive();
        cycle(); cycle();
        clear_logs();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (tx_v !== 1'b0) begin errors++; $display("FAIL reset_tx_v: got %b want 0", tx_v); end
        checks++; if (req_rdy !== 4'b0000) begin errors++; $display("FAIL reset_rdy: got %b want 0000", req_rdy); end
        checks++; if (tx_d !== 8'h00) begin errors++; $display("FAIL reset_tx_d: got %h want 00", tx_d); end
        rst_n = 1'b1;
        cycle();
        checks++; if (gnt !== 4'b0010 || busy !== 1'b1) begin errors++; $display("FAIL reset_first_grant: got gnt=%b busy=%b want 0010/1", gnt, busy); end
        checks++; if (tx_d !== 8'h33) begin errors++; $display("FAIL reset_first_byte: got %h want 33", tx_d); end
        cycle();
        checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("FAIL reset_release: got gnt=%b busy=%b want 0000/0", gnt, busy); end
    endtask

    task automatic test_single_burst();
        do_reset();
        push(2, 8'hA1, 1'b0); push(2, 8'hA2, 1'b0); push(2, 8'hA3, 1'b1);
        drive();
        #1;
        checks++; if (busy !== 1'b0 || gnt !== 4'b0000 || tx_v !== 1'b0 || req_rdy !== 4'b0000) begin
            errors++; $display("FAIL single_arb_cycle: got busy=%b gnt=%b tx_v=%b rdy=%b want 0/0000/0/0000", busy, gnt, tx_v, req_rdy); end
        cycle();
        checks++; if (gnt !== 4'b0100 || busy !== 1'b1) begin errors++; $display("FAIL single_gnt: got gnt=%b busy=%b want 0100/1", gnt, busy); end
        checks++; if (tx_d !== 8'hA1 || tx_v !== 1'b1 || req_rdy !== 4'b0100) begin
            errors++; $display("FAIL single_byte1: got d=%h v=%b rdy=%b want A1/1/0100", tx_d, tx_v, req_rdy); end
        cycle();
        checks++; if (tx_d !== 8'hA2) begin errors++; $display("FAIL single_byte2: got %h want A2", tx_d); end
        cycle();
        checks++; if (tx_d !== 8'hA3) begin errors++; $display("FAIL single_byte3: got %h want A3", tx_d); end
        cycle();
        checks++; if (busy !== 1'b0 || gnt !== 4'b0000) begin errors++; $display("FAIL single_release: got busy=%b gnt=%b want 0/0000", busy, gnt); end
        exp_q.push_back({8'd2, 8'hA1}); exp_q.push_back({8'd2, 8'hA2}); exp_q.push_back({8'd2, 8'hA3});
        checks++; if (xfer_log.size() != exp_q.size()) begin errors++; $display("FAIL single_count: got %0d want %0d", xfer_log.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (xfer_log[i] !== exp_q[i]) begin errors++; $display("FAIL single_log[%0d]: got %h want %h", i, xfer_log[i], exp_q[i]); end
            if (i > 0) begin
                checks++; if (xfer_cyc[i] - xfer_cyc[i-1] != 1) begin errors++; $display("FAIL single_consecutive[%0d]: got gap %0d want 1", i, xfer_cyc[i] - xfer_cyc[i-1]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        push(0, 8'h10, 1'b0); push(0, 8'h11, 1'b1);
        push(1, 8'h20, 1'b0); push(1, 8'h21, 1'b1);
        drive();
        run_idle(40, to);
        checks++; if (to) begin errors++; $display("FAIL b2b_timeout: got pending after 40 cycles want idle"); end
        exp_q.push_back({8'd0, 8'h10}); exp_q.push_back({8'd0, 8'h11});
        exp_q.push_back({8'd1, 8'h20}); exp_q.push_back({8'd1, 8'h21});
        checks++; if (xfer_log.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d want %0d", xfer_log.size(), exp_q.size()); end
        else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++; if (xfer_log[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_log[%0d]: got %h want %h", i, xfer_log[i], exp_q[i]); end
            end
            checks++; if (xfer_cyc[1] - xfer_cyc[0] != 1) begin errors++; $display("FAIL b2b_burst0_gap: got %0d want 1", xfer_cyc[1] - xfer_cyc[0]); end
            checks++; if (xfer_cyc[2] - xfer_cyc[1] != 2) begin errors++; $display("FAIL b2b_inter_burst_gap: got %0d want 2", xfer_cyc[2] - xfer_cyc[1]); end
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL b2b_no_idle_between: got %0d direct handovers want 0", viol); end
    endtask

    task automatic test_fairness();
        do_reset();
        for (int n = 1; n <= 2; n++)
            for (int k = 0; k < NR; k++) push(k, 8'(k*16 + n), 1'b1);
        drive();
        run_idle(100, to);
        checks++; if (to) begin errors++; $display("FAIL rr_timeout: got pending after 100 cycles want idle"); end
        for (int n = 1; n <= 2; n++)
            for (int k = 0; k < NR; k++) begin
                exp_g.push_back(8'(k));
                exp_q.push_back({8'(k), 8'(k*16 + n)});
            end
        checks++; if (gnt_log.size() != exp_g.size()) begin errors++; $display("FAIL rr_grants: got %0d want %0d", gnt_log.size(), exp_g.size()); end
        else for (int i = 0; i < exp_g.size(); i++) begin
            checks++; if (gnt_log[i] !== exp_g[i]) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, gnt_log[i], exp_g[i]); end
        end
        checks++; if (xfer_log.size() != exp_q.size()) begin errors++; $display("FAIL rr_count: got %0d want %0d", xfer_log.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (xfer_log[i] !== exp_q[i]) begin errors++; $display("FAIL rr_log[%0d]: got %h want %h", i, xfer_log[i], exp_q[i]); end
        end
    endtask

    task automatic test_max_burst();
        do_reset();
        for (int i = 0; i < 20; i++) push(1, 8'(8'h40 + i), (i == 19));
        push(3, 8'h80, 1'b0); push(3, 8'h81, 1'b1);
        drive();
        run_idle(200, to);
        checks++; if (to) begin errors++; $display("FAIL maxb_timeout: got pending after 200 cycles want idle"); end
        exp_g.push_back(8'd1); exp_g.push_back(8'd3); exp_g.push_back(8'd1);
        for (int i = 0; i < 16; i++) exp_q.push_back({8'd1, 8'(8'h40 + i)});
        exp_q.push_back({8'd3, 8'h80}); exp_q.push_back({8'd3, 8'h81});
        for (int i = 16; i < 20; i++) exp_q.push_back({8'd1, 8'(8'h40 + i)});
        checks++; if (gnt_log.size() != exp_g.size()) begin errors++; $display("FAIL maxb_grants: got %0d want %0d", gnt_log.size(), exp_g.size()); end
        else for (int i = 0; i < exp_g.size(); i++) begin
            checks++; if (gnt_log[i] !== exp_g[i]) begin errors++; $display("FAIL maxb_order[%0d]: got %0d want %0d", i, gnt_log[i], exp_g[i]); end
        end
        checks++; if (xfer_log.size() != exp_q.size()) begin errors++; $display("FAIL maxb_count: got %0d want %0d", xfer_log.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (xfer_log[i] !== exp_q[i]) begin errors++; $display("FAIL maxb_log[%0d]: got %h want %h", i, xfer_log[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 6; i++) push(0, 8'(8'h50 + i), (i == 5));
        push(2, 8'h99, 1'b1);
        drive();
        cycle();
        checks++; if (gnt !== 4'b0001 || tx_d !== 8'h50) begin errors++; $display("FAIL bp_grant: got gnt=%b d=%h want 0001/50", gnt, tx_d); end
        cycle();
        tx_rdy = 1'b0;
        #1;
        checks++; if (tx_d !== 8'h51 || tx_v !== 1'b1 || req_rdy !== 4'b0000) begin
            errors++; $display("FAIL bp_stall_start: got d=%h v=%b rdy=%b want 51/1/0000", tx_d, tx_v, req_rdy); end
        for (int n = 0; n < 5; n++) begin
            cycle();
            checks++; if (gnt !== 4'b0001 || tx_d !== 8'h51 || req_rdy !== 4'b0000) begin
                errors++; $display("FAIL bp_hold[%0d]: got gnt=%b d=%h rdy=%b want 0001/51/0000", n, gnt, tx_d, req_rdy); end
        end
        tx_rdy = 1'b1;
        #1;
        checks++; if (req_rdy !== 4'b0001) begin errors++; $display("FAIL bp_rdy_follow: got %b want 0001", req_rdy); end
        cycle();
        stall[0] = 1'b1;
        drive();
        #1;
        checks++; if (tx_v !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL bp_req_drop: got v=%b busy=%b want 0/1", tx_v, busy); end
        for (int n = 0; n < 3; n++) begin
            cycle();
            checks++; if (gnt !== 4'b0001 || tx_v !== 1'b0) begin
                errors++; $display("FAIL bp_req_gap[%0d]: got gnt=%b v=%b want 0001/0", n, gnt, tx_v); end
        end
        stall[0] = 1'b0;
        drive();
        run_idle(60, to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout: got pending after 60 cycles want idle"); end
        for (int i = 0; i < 6; i++) exp_q.push_back({8'd0, 8'(8'h50 + i)});
        exp_q.push_back({8'd2, 8'h99});
        checks++; if (xfer_log.size() != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d want %0d", xfer_log.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (xfer_log[i] !== exp_q[i]) begin errors++; $display("FAIL bp_log[%0d]: got %h want %h", i, xfer_log[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 4; i++) push(3, 8'(8'h60 + i), (i == 3));
        drive();
        cycle();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL rmid_grant3: got %b want 1000", gnt); end
        push(0, 8'h70, 1'b1);
        drive();
        cycle(); cycle();
        rst_n = 1'b0;
        cycle();
        checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || tx_v !== 1'b0) begin
            errors++; $display("FAIL rmid_abort: got gnt=%b busy=%b v=%b want 0000/0/0", gnt, busy, tx_v); end
        rst_n = 1'b1;
        cycle();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rmid_next_grant: got %b want 0001", gnt); end
        run_idle(60, to);
        checks++; if (to) begin errors++; $display("FAIL rmid_timeout: got pending after 60 cycles want idle"); end
        exp_q.push_back({8'd3, 8'h60}); exp_q.push_back({8'd3, 8'h61}); exp_q.push_back({8'd0, 8'h70});
        exp_q.push_back({8'd3, 8'h62}); exp_q.push_back({8'd3, 8'h63});
        checks++; if (xfer_log.size() != exp_q.size()) begin errors++; $display("FAIL rmid_count: got %0d want %0d", xfer_log.size(), exp_q.size()); end
        else for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (xfer_log[i] !== exp_q[i]) begin errors++; $display("FAIL rmid_log[%0d]: got %h want %h", i, xfer_log[i], exp_q[i]); end
        end
    endtask

    initial begin
        errors = 0; checks = 0; cyc = 0; viol = 0;
        prev_gnt = '0; acc = '0; stall = '0; to = 1'b0;
        rst_n = 1'b0; tx_rdy = 1'b1;
        req_v = '0; req_d = '0; req_last = '0;
        test_reset();
        test_single_burst();
        test_back_to_back();
        test_fairness();
        test_max_burst();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
